cix32_imem_responder: RTL

Instruction-memory responder for CIX-32: the target side of the `imem_req`/`imem_ready` interface driven by `cix32_fetch`. It holds a word-organised code store and returns 4 little-endian bytes starting at any byte address, including unaligned addresses. It inserts a programmable number of wait states and flags out-of-window fetches, including the fetch unit's CS-limit marker address 32'hFFFFFFFF. In simulation and FPGA builds it sits between the fetch unit and the program image, and the bench preloads it through a load port.

---
 rtl/cix32_imem_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cix32_imem_responder.sv
// CIX-32 instruction-memory responder: word-organised code store returning 4 little-endian
// bytes from any byte address, with programmable wait states and out-of-window fault flagging.
//
// state  | meaning
// IDLE   | waiting for imem_req; accept latches address, fault flag and wait count
// WAIT   | counting wait states, then first array read (or fault response)
// SECOND | second array read for an unaligned fetch, merge bytes
// RESP   | imem_ready high for this one cycle
module cix32_imem_responder #(
    parameter logic [31:0] MEM_BASE    = 32'h000F0000,
    parameter int          MEM_WORDS   = 16384,
    parameter int          WAIT_STATES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         imem_req,
    input  logic [31:0]                  imem_addr,
    output logic [31:0]                  imem_rdata,
    output logic                         imem_ready,
    output logic                         imem_fault,
    output logic                         busy,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [31:0]                  ld_data
);

    localparam int          AW       = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_LAST = {1'b0, MEM_BASE} + (33'(MEM_WORDS) << 2) - 33'd1;
    localparam logic [31:0] HLT_WORD = 32'hF4F4F4F4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SECOND,
        ST_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   a_q, a_d;
    logic          flt_q, flt_d;
    logic [31:0]   word0_q, word0_d;
    logic [31:0]   rdata_d;
    logic          ready_d;
    logic          fault_d;
    logic          busy_d;

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] idx0;
    logic [AW-1:0] idx1;
    logic [31:0]   mem_w0;
    logic [31:0]   mem_w1;
    logic [63:0]   pair;
    logic [31:0]   merged;
    logic          accept_flt;

    // Preload port; reads elsewhere see only data from earlier edges.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign idx0   = AW'((a_q - MEM_BASE) >> 2);
    assign idx1   = idx0 + AW'(1);
    assign mem_w0 = mem[idx0];
    assign mem_w1 = mem[idx1];
    assign pair   = {mem_w1, word0_q};
    assign merged = pair[{1'b0, a_q[1:0], 3'b000} +: 32];

    // 33-bit compare so the all-ones CS-limit marker cannot wrap into the window.
    assign accept_flt = ({1'b0, imem_addr} < {1'b0, MEM_BASE}) ||
                        (({1'b0, imem_addr} + 33'd3) > MEM_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        flt_d   = flt_q;
        word0_d = word0_q;
        rdata_d = imem_rdata;
        ready_d = 1'b0;
        fault_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (imem_req) begin
                    a_d     = imem_addr;
                    cnt_d   = 4'(WAIT_STATES);
                    flt_d   = accept_flt;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!imem_req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (flt_q) begin
                    rdata_d = HLT_WORD;
                    ready_d = 1'b1;
                    fault_d = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    word0_d = mem_w0;
                    if (a_q[1:0] == 2'd0) begin
                        rdata_d = mem_w0;
                        ready_d = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_SECOND;
                    end
                end
            end
            ST_SECOND: begin
                if (!imem_req) begin
                    state_d = ST_IDLE;
                end else begin
                    rdata_d = merged;
                    ready_d = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            a_q        <= 32'd0;
            flt_q      <= 1'b0;
            word0_q    <= 32'd0;
            imem_rdata <= 32'd0;
            imem_ready <= 1'b0;
            imem_fault <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            flt_q      <= flt_d;
            word0_q    <= word0_d;
            imem_rdata <= rdata_d;
            imem_ready <= ready_d;
            imem_fault <= fault_d;
            busy       <= busy_d;
        end
    end

endmodule
